// File: rtl/bus_timer_slave_pkg.sv
// Shared constants and types for the bus timer slave: register offsets,
// CTRL bit layout, reset values and the byte-enable merge helper.
package bus_timer_slave_pkg;

    localparam int TIMER_DATA_W = 32;
    localparam int TIMER_ADDR_W = 32;
    localparam int TIMER_MASK_W = TIMER_DATA_W / 8;
    localparam int TIMER_PRESC_W = 16;

    typedef enum logic [1:0] {
        TIMER_OFF_CTRL  = 2'd0,
        TIMER_OFF_COUNT = 2'd1,
        TIMER_OFF_CMP   = 2'd2,
        TIMER_OFF_PRESC = 2'd3
    } timer_off_e;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IE     = 1;
    localparam int CTRL_PEND   = 2;
    localparam int CTRL_RELOAD = 3;

    typedef struct packed {
        logic reload;
        logic pend;
        logic ie;
        logic en;
    } timer_ctrl_t;

    localparam logic [TIMER_DATA_W-1:0] TIMER_CMP_RST = 32'hFFFF_FFFF;

    function automatic logic [TIMER_DATA_W-1:0] wem_merge(
        input logic [TIMER_DATA_W-1:0] old,
        input logic [TIMER_DATA_W-1:0] d,
        input logic [TIMER_MASK_W-1:0] m
    );
        logic [TIMER_DATA_W-1:0] r;
        for (int i = 0; i < TIMER_MASK_W; i++)
            r[8*i +: 8] = m[i] ? d[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/bus_timer_slave_if.sv
// req/addr_ok/data_ok bus between the arbiter (master) and the timer (slave).
interface bus_timer_slave_if
    import bus_timer_slave_pkg::*;
#(
    parameter int DATA_W = TIMER_DATA_W,
    parameter int ADDR_W = TIMER_ADDR_W,
    parameter int MASK_W = TIMER_MASK_W
);
    logic              req_i;
    logic              we_i;
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] data_i;
    logic [MASK_W-1:0] wem_i;
    logic              addr_ok_o;
    logic              data_ok_o;
    logic [DATA_W-1:0] data_o;

    modport master (
        output req_i, we_i, addr_i, data_i, wem_i,
        input  addr_ok_o, data_ok_o, data_o
    );

    modport slave (
        input  req_i, we_i, addr_i, data_i, wem_i,
        output addr_ok_o, data_ok_o, data_o
    );
endinterface

// File: rtl/bus_timer_slave_prescaler.sv
// Tick divider for the timer: pulses once every PRESC+1 enabled cycles.
// Only compiled when TIMER_PRESCALER_EN is defined.
`ifdef TIMER_PRESCALER_EN
module bus_timer_slave_prescaler
    import bus_timer_slave_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [TIMER_PRESC_W-1:0] presc,
    input  logic                     clr,
    output logic                     tick
);
    logic [TIMER_PRESC_W-1:0] cnt;

    assign tick = en && (cnt == presc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)               cnt <= '0;
        else if (clr || tick)  cnt <= '0;
        else                   cnt <= cnt + TIMER_PRESC_W'(1);
    end
endmodule
`endif

// File: rtl/bus_timer_slave.sv
// Timer peripheral on arbiter slave port 2: 32-bit counter with compare,
// auto-reload and level irq. Optional PRESC register under TIMER_PRESCALER_EN.
module bus_timer_slave
    import bus_timer_slave_pkg::*;
#(
    parameter int DATA_W = TIMER_DATA_W,
    parameter int ADDR_W = TIMER_ADDR_W,
    parameter int MASK_W = TIMER_MASK_W
) (
    input  logic             clk,
    input  logic             rst,
    bus_timer_slave_if.slave bus,
    output logic             irq_o
);
    logic              addr_ok, data_ok;
    logic [DATA_W-1:0] data_q, rd_val;
    timer_ctrl_t       ctrl, ctrl_n;
    logic [DATA_W-1:0] count, count_n, cmp, cmp_n;
    logic              accept, wr, tick, match;
    timer_off_e        sel;
    logic              unused_addr;

    assign accept      = bus.req_i && addr_ok;
    assign wr          = accept && bus.we_i;
    assign sel         = timer_off_e'(bus.addr_i[3:2]);
    assign unused_addr = ^{bus.addr_i[ADDR_W-1:4], bus.addr_i[1:0]};

`ifdef TIMER_PRESCALER_EN
    logic [TIMER_PRESC_W-1:0] presc, presc_n;
    logic [DATA_W-1:0]        presc_w;
    logic                     presc_wr;

    assign presc_wr = wr && (sel == TIMER_OFF_PRESC);
    assign presc_w  = wem_merge({{(DATA_W-TIMER_PRESC_W){1'b0}}, presc}, bus.data_i, bus.wem_i);

    bus_timer_slave_prescaler u_timer_prescaler (
        .clk   (clk),
        .rst   (rst),
        .en    (ctrl.en),
        .presc (presc),
        .clr   (!ctrl.en || presc_wr),
        .tick  (tick)
    );
`else
    assign tick = ctrl.en;
`endif

    assign match = tick && (count == cmp);

    always_comb begin
        rd_val = '0;
        case (sel)
            TIMER_OFF_CTRL:  rd_val = {{(DATA_W-4){1'b0}}, ctrl};
            TIMER_OFF_COUNT: rd_val = count;
            TIMER_OFF_CMP:   rd_val = cmp;
`ifdef TIMER_PRESCALER_EN
            TIMER_OFF_PRESC: rd_val = {{(DATA_W-TIMER_PRESC_W){1'b0}}, presc};
`endif
            default:         rd_val = '0;
        endcase
    end

    // Tick update first, then bus write overrides it, then a fresh match
    // re-asserts pend so it wins over a same-cycle W1C.
    always_comb begin
        ctrl_n  = ctrl;
        count_n = count;
        cmp_n   = cmp;
`ifdef TIMER_PRESCALER_EN
        presc_n = presc;
`endif
        if (tick) begin
            if (count == cmp) begin
                if (ctrl.reload) count_n   = '0;
                else             ctrl_n.en = 1'b0;
            end else begin
                count_n = count + DATA_W'(1);
            end
        end
        if (wr) begin
            case (sel)
                TIMER_OFF_CTRL: if (bus.wem_i[0]) begin
                    ctrl_n.en     = bus.data_i[CTRL_EN];
                    ctrl_n.ie     = bus.data_i[CTRL_IE];
                    ctrl_n.reload = bus.data_i[CTRL_RELOAD];
                    if (bus.data_i[CTRL_PEND]) ctrl_n.pend = 1'b0;
                end
                TIMER_OFF_COUNT: count_n = wem_merge(count, bus.data_i, bus.wem_i);
                TIMER_OFF_CMP:   cmp_n   = wem_merge(cmp, bus.data_i, bus.wem_i);
`ifdef TIMER_PRESCALER_EN
                TIMER_OFF_PRESC: presc_n = presc_w[TIMER_PRESC_W-1:0];
`endif
                default: ;
            endcase
        end
        if (match) ctrl_n.pend = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_ok <= 1'b0;
            data_ok <= 1'b0;
            data_q  <= '0;
            ctrl    <= '0;
            count   <= '0;
            cmp     <= TIMER_CMP_RST;
`ifdef TIMER_PRESCALER_EN
            presc   <= '0;
`endif
        end else begin
            addr_ok <= 1'b1;
            data_ok <= accept;
            data_q  <= (accept && !bus.we_i) ? rd_val : '0;
            ctrl    <= ctrl_n;
            count   <= count_n;
            cmp     <= cmp_n;
`ifdef TIMER_PRESCALER_EN
            presc   <= presc_n;
`endif
        end
    end

    assign bus.addr_ok_o = addr_ok;
    assign bus.data_ok_o = data_ok;
    assign bus.data_o    = data_q;
    assign irq_o         = ctrl.pend && ctrl.ie;
endmodule
